// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter sharing one sigmoid unit between N requesters.
// A grant is held for the whole arg->res (and, when training, err->fbk) transaction.
module sigmoid_arbiter_lane (
  input  logic sel_i,
  input  logic st_arg_i,
  input  logic st_res_i,
  input  logic st_err_i,
  input  logic st_fbk_i,
  input  logic act_arg_rdy_i,
  input  logic act_res_stb_i,
  input  logic act_err_rdy_i,
  input  logic act_fbk_stb_i,
  output logic arg_rdy_o,
  output logic res_stb_o,
  output logic err_rdy_o,
  output logic fbk_stb_o
);
  assign arg_rdy_o = sel_i & st_arg_i & act_arg_rdy_i;
  assign res_stb_o = sel_i & st_res_i & act_res_stb_i;
  assign err_rdy_o = sel_i & st_err_i & act_err_rdy_i;
  assign fbk_stb_o = sel_i & st_fbk_i & act_fbk_stb_i;
endmodule

module sigmoid_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req_arg_stb,
  input  logic [16*N-1:0] req_arg_dat,
  output logic [N-1:0]    req_arg_rdy,
  output logic [N-1:0]    req_res_stb,
  output logic [7:0]      req_res_dat,
  input  logic [N-1:0]    req_res_rdy,
  input  logic [N-1:0]    req_err_stb,
  input  logic [16*N-1:0] req_err_dat,
  output logic [N-1:0]    req_err_rdy,
  output logic [N-1:0]    req_fbk_stb,
  output logic [15:0]     req_fbk_dat,
  input  logic [N-1:0]    req_fbk_rdy,
  output logic            act_en,
  output logic            act_arg_stb,
  output logic [15:0]     act_arg_dat,
  input  logic            act_arg_rdy,
  input  logic            act_res_stb,
  input  logic [7:0]      act_res_dat,
  output logic            act_res_rdy,
  output logic            act_err_stb,
  output logic [15:0]     act_err_dat,
  input  logic            act_err_rdy,
  input  logic            act_fbk_stb,
  input  logic [15:0]     act_fbk_dat,
  output logic            act_fbk_rdy,
  output logic [IW-1:0]   gnt,
  output logic            busy,
  output logic [15:0]     cnt
);
  typedef enum logic [2:0] {S_IDLE, S_ARG, S_RES, S_ERR, S_FBK} state_t;

  state_t          state_q;
  logic [IW-1:0]   gnt_q, ptr_q, ptr_d, pick, idx;
  logic            en_q, found, done;
  logic [15:0]     cnt_q, cnt_d;
  logic            st_arg, st_res, st_err, st_fbk;

  assign st_arg = (state_q == S_ARG);
  assign st_res = (state_q == S_RES);
  assign st_err = (state_q == S_ERR);
  assign st_fbk = (state_q == S_FBK);

  // First strobing requester at or after ptr, wrapping mod N.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr_q) + k) % N);
      if (!found && req_arg_stb[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign act_arg_stb = st_arg & req_arg_stb[gnt_q];
  assign act_arg_dat = req_arg_dat[{gnt_q, 4'b0000} +: 16];
  assign act_res_rdy = st_res & req_res_rdy[gnt_q];
  assign act_err_stb = st_err & req_err_stb[gnt_q];
  assign act_err_dat = req_err_dat[{gnt_q, 4'b0000} +: 16];
  assign act_fbk_rdy = st_fbk & req_fbk_rdy[gnt_q];

  assign req_res_dat = act_res_dat;
  assign req_fbk_dat = act_fbk_dat;
  assign act_en      = en_q;
  assign gnt         = gnt_q;
  assign busy        = (state_q != S_IDLE);
  assign cnt         = cnt_q;

  assign done  = (act_res_stb & act_res_rdy & ~en_q) | (act_fbk_stb & act_fbk_rdy);
  assign ptr_d = (gnt_q == IW'(N-1)) ? '0 : gnt_q + 1'b1;
  assign cnt_d = cnt_q + 16'd1;

  for (genvar i = 0; i < N; i++) begin : g_lane
    sigmoid_arbiter_lane u_lane (
      .sel_i        (gnt_q == IW'(i)),
      .st_arg_i     (st_arg),
      .st_res_i     (st_res),
      .st_err_i     (st_err),
      .st_fbk_i     (st_fbk),
      .act_arg_rdy_i(act_arg_rdy),
      .act_res_stb_i(act_res_stb),
      .act_err_rdy_i(act_err_rdy),
      .act_fbk_stb_i(act_fbk_stb),
      .arg_rdy_o    (req_arg_rdy[i]),
      .res_stb_o    (req_res_stb[i]),
      .err_rdy_o    (req_err_rdy[i]),
      .fbk_stb_o    (req_fbk_stb[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (done) begin
        ptr_q <= ptr_d;
        cnt_q <= cnt_d;
      end
      case (state_q)
        S_IDLE: if (found) begin
          gnt_q   <= pick;
          en_q    <= en;
          state_q <= S_ARG;
        end
        S_ARG: if (act_arg_stb && act_arg_rdy) state_q <= S_RES;
        S_RES: if (act_res_stb && act_res_rdy) state_q <= en_q ? S_ERR : S_IDLE;
        S_ERR: if (act_err_stb && act_err_rdy) state_q <= S_FBK;
        S_FBK: if (act_fbk_stb && act_fbk_rdy) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Directed bench for sigmoid_arbiter (N=4): the bench plays both requesters and sigmoid.
module tb_sigmoid_arbiter;
  localparam int N = 4;
  localparam int IW = 2;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [N-1:0] req_arg_stb = '0, req_arg_rdy, req_res_stb, req_res_rdy = '0;
  logic [16*N-1:0] req_arg_dat = '0, req_err_dat = '0;
  logic [7:0] req_res_dat;
  logic [N-1:0] req_err_stb = '0, req_err_rdy, req_fbk_stb, req_fbk_rdy = '0;
  logic [15:0] req_fbk_dat;
  logic act_en, act_arg_stb, act_arg_rdy = 1'b0;
  logic [15:0] act_arg_dat;
  logic act_res_stb = 1'b0, act_res_rdy;
  logic [7:0] act_res_dat = '0;
  logic act_err_stb, act_err_rdy = 1'b0;
  logic [15:0] act_err_dat;
  logic act_fbk_stb = 1'b0, act_fbk_rdy;
  logic [15:0] act_fbk_dat = '0;
  logic [IW-1:0] gnt;
  logic busy;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;

  sigmoid_arbiter #(.N(N), .IW(IW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_arg_stb(req_arg_stb), .req_arg_dat(req_arg_dat), .req_arg_rdy(req_arg_rdy),
    .req_res_stb(req_res_stb), .req_res_dat(req_res_dat), .req_res_rdy(req_res_rdy),
    .req_err_stb(req_err_stb), .req_err_dat(req_err_dat), .req_err_rdy(req_err_rdy),
    .req_fbk_stb(req_fbk_stb), .req_fbk_dat(req_fbk_dat), .req_fbk_rdy(req_fbk_rdy),
    .act_en(act_en),
    .act_arg_stb(act_arg_stb), .act_arg_dat(act_arg_dat), .act_arg_rdy(act_arg_rdy),
    .act_res_stb(act_res_stb), .act_res_dat(act_res_dat), .act_res_rdy(act_res_rdy),
    .act_err_stb(act_err_stb), .act_err_dat(act_err_dat), .act_err_rdy(act_err_rdy),
    .act_fbk_stb(act_fbk_stb), .act_fbk_dat(act_fbk_dat), .act_fbk_rdy(act_fbk_rdy),
    .gnt(gnt), .busy(busy), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one non-training transaction; returns the granted index and leaves FSM in IDLE.
  task automatic txn(input logic [N-1:0] stbs, output logic [IW-1:0] g);
    req_arg_stb = stbs; act_arg_rdy = 1'b1;
    tick();
    g = gnt;
    tick();
    req_arg_stb = '0; act_res_stb = 1'b1; req_res_rdy = '1;
    tick();
    act_res_stb = 1'b0; req_res_rdy = '0;
  endtask

  task automatic test_reset;
    act_arg_rdy = 1'b1; act_fbk_stb = 1'b1; req_arg_stb = 4'b1111;
    #1;
    checks++;
    if ({busy, gnt, cnt, act_en} !== 20'h0) begin
      errors++; $display("FAIL reset_state: busy=%0b gnt=%0d cnt=%0d act_en=%0b, want 0", busy, gnt, cnt, act_en);
    end
    checks++;
    if ({req_arg_rdy, req_res_stb, req_err_rdy, req_fbk_stb, act_arg_stb, act_res_rdy, act_err_stb, act_fbk_rdy} !== 20'h0) begin
      errors++; $display("FAIL reset_gating: arg_rdy=%b fbk_stb=%b act_arg_stb=%b, want 0", req_arg_rdy, req_fbk_stb, act_arg_stb);
    end
    req_arg_stb = '0; act_arg_rdy = 1'b0; act_fbk_stb = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [IW-1:0] g;
    req_arg_dat = 64'h0000_0100_0000_0000; req_arg_stb = 4'b0100; act_arg_rdy = 1'b1;
    #1;
    checks++;
    if ({busy, act_arg_stb, req_arg_rdy} !== 6'b0) begin
      errors++; $display("FAIL single_idle: busy=%0b act_arg_stb=%0b arg_rdy=%b, want 0", busy, act_arg_stb, req_arg_rdy);
    end
    tick();
    checks++;
    if ({busy, gnt, act_arg_stb, act_arg_dat, req_arg_rdy} !== {1'b1, 2'd2, 1'b1, 16'h0100, 4'b0100}) begin
      errors++; $display("FAIL single_arg: busy=%0b gnt=%0d stb=%0b dat=%h rdy=%b, want 1 2 1 0100 0100", busy, gnt, act_arg_stb, act_arg_dat, req_arg_rdy);
    end
    tick();
    req_arg_stb = '0; act_res_stb = 1'b1; act_res_dat = 8'h5a; req_res_rdy = 4'b1111;
    #1;
    checks++;
    if ({req_res_stb, req_res_dat, act_res_rdy} !== {4'b0100, 8'h5a, 1'b1}) begin
      errors++; $display("FAIL single_res: res_stb=%b dat=%h act_res_rdy=%0b, want 0100 5a 1", req_res_stb, req_res_dat, act_res_rdy);
    end
    tick();
    act_res_stb = 1'b0; req_res_rdy = '0;
    checks++;
    if ({busy, cnt} !== {1'b0, 16'd1}) begin
      errors++; $display("FAIL single_done: busy=%0b cnt=%0d, want 0 1", busy, cnt);
    end
    // ptr is now 3, so of requesters 1 and 3, 3 wins.
    txn(4'b1010, g);
    checks++;
    if (g !== 2'd3) begin
      errors++; $display("FAIL single_ptr: gnt=%0d, want 3", g);
    end
  endtask

  task automatic test_contention;
    logic [IW-1:0] g0, g1, g2, g3;
    txn(4'b1011, g0);
    txn(4'b1010, g1);
    txn(4'b1000, g2);
    txn(4'b0001, g3);
    checks++;
    if ({g0, g1, g2, g3} !== {2'd0, 2'd1, 2'd3, 2'd0}) begin
      errors++; $display("FAIL contention_order: %0d %0d %0d %0d, want 0 1 3 0", g0, g1, g2, g3);
    end
    checks++;
    if (cnt !== 16'd6) begin
      errors++; $display("FAIL contention_cnt: cnt=%0d, want 6", cnt);
    end
  endtask

  task automatic test_training;
    en = 1'b1; req_arg_stb = 4'b0010; act_arg_rdy = 1'b1;
    tick();
    checks++;
    if ({gnt, act_en} !== {2'd1, 1'b1}) begin
      errors++; $display("FAIL train_grant: gnt=%0d act_en=%0b, want 1 1", gnt, act_en);
    end
    tick();
    req_arg_stb = '0; act_res_stb = 1'b1; req_res_rdy = 4'b0010;
    tick();
    act_res_stb = 1'b0; req_res_rdy = '0;
    req_err_dat = 64'h0000_0000_0200_0000; req_err_stb = 4'b0010; act_err_rdy = 1'b1;
    #1;
    checks++;
    if ({busy, act_err_stb, act_err_dat, req_err_rdy} !== {1'b1, 1'b1, 16'h0200, 4'b0010}) begin
      errors++; $display("FAIL train_err: busy=%0b stb=%0b dat=%h rdy=%b, want 1 1 0200 0010", busy, act_err_stb, act_err_dat, req_err_rdy);
    end
    tick();
    req_err_stb = '0; act_fbk_stb = 1'b1; act_fbk_dat = 16'hbeef; req_fbk_rdy = 4'b1111;
    #1;
    checks++;
    if ({req_fbk_stb, req_fbk_dat, act_fbk_rdy, act_err_stb} !== {4'b0010, 16'hbeef, 1'b1, 1'b0}) begin
      errors++; $display("FAIL train_fbk: fbk_stb=%b dat=%h rdy=%0b err_stb=%0b, want 0010 beef 1 0", req_fbk_stb, req_fbk_dat, act_fbk_rdy, act_err_stb);
    end
    tick();
    act_fbk_stb = 1'b0; req_fbk_rdy = '0;
    checks++;
    if ({busy, cnt} !== {1'b0, 16'd7}) begin
      errors++; $display("FAIL train_done: busy=%0b cnt=%0d, want 0 7", busy, cnt);
    end
  endtask

  task automatic test_en_toggle;
    en = 1'b1; req_arg_stb = 4'b1000; act_arg_rdy = 1'b1;
    tick();
    tick();
    req_arg_stb = '0; en = 1'b0; act_res_stb = 1'b1; req_res_rdy = 4'b1111;
    #1;
    checks++;
    if (act_en !== 1'b1) begin
      errors++; $display("FAIL entog_res_act_en: act_en=%0b, want 1", act_en);
    end
    tick();
    act_res_stb = 1'b0; req_res_rdy = '0; req_err_stb = 4'b1000; act_err_rdy = 1'b1;
    #1;
    checks++;
    if ({busy, act_en, act_err_stb, req_err_rdy} !== {1'b1, 1'b1, 1'b1, 4'b1000}) begin
      errors++; $display("FAIL entog_err: busy=%0b act_en=%0b err_stb=%0b err_rdy=%b, want 1 1 1 1000", busy, act_en, act_err_stb, req_err_rdy);
    end
    tick();
    req_err_stb = '0; act_fbk_stb = 1'b1; req_fbk_rdy = 4'b1000;
    tick();
    act_fbk_stb = 1'b0; req_fbk_rdy = '0;
    checks++;
    if ({busy, cnt} !== {1'b0, 16'd8}) begin
      errors++; $display("FAIL entog_done: busy=%0b cnt=%0d, want 0 8", busy, cnt);
    end
  endtask

  task automatic test_backpressure;
    req_arg_stb = 4'b0001; act_arg_rdy = 1'b1;
    tick();
    tick();
    req_arg_stb = '0; act_res_stb = 1'b1; req_res_rdy = 4'b1110;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({act_res_rdy, busy, req_arg_rdy, req_err_rdy, req_fbk_stb, req_res_stb} !== {1'b0, 1'b1, 12'h0, 4'b0001}) begin
        errors++; $display("FAIL bp_hold[%0d]: res_rdy=%0b busy=%0b arg_rdy=%b res_stb=%b, want 0 1 0000 0001", c, act_res_rdy, busy, req_arg_rdy, req_res_stb);
      end
      tick();
    end
    req_res_rdy = 4'b0001;
    tick();
    act_res_stb = 1'b0; req_res_rdy = '0;
    checks++;
    if ({busy, cnt} !== {1'b0, 16'd9}) begin
      errors++; $display("FAIL bp_done: busy=%0b cnt=%0d, want 0 9", busy, cnt);
    end
  endtask

  task automatic test_reset_mid;
    logic [IW-1:0] g;
    en = 1'b1; req_arg_stb = 4'b0100; act_arg_rdy = 1'b1;
    tick();
    tick();
    req_arg_stb = '0; act_res_stb = 1'b1; req_res_rdy = 4'b0100;
    tick();
    act_res_stb = 1'b0; req_res_rdy = '0; req_err_stb = 4'b0100; act_err_rdy = 1'b1;
    tick();
    req_err_stb = '0; act_fbk_stb = 1'b1; req_fbk_rdy = '0;
    #1;
    checks++;
    if (req_fbk_stb !== 4'b0100) begin
      errors++; $display("FAIL rstmid_fbk: fbk_stb=%b, want 0100", req_fbk_stb);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, gnt, cnt, act_en, req_fbk_stb, act_fbk_rdy} !== 25'h0) begin
      errors++; $display("FAIL rstmid_async: busy=%0b gnt=%0d cnt=%0d act_en=%0b fbk_stb=%b, want 0", busy, gnt, cnt, act_en, req_fbk_stb);
    end
    act_fbk_stb = 1'b0; en = 1'b0;
    tick();
    rst = 1'b0;
    txn(4'b1010, g);
    checks++;
    if ({g, cnt} !== {2'd1, 16'd1}) begin
      errors++; $display("FAIL rstmid_regrant: gnt=%0d cnt=%0d, want 1 1", g, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_training();
    test_en_toggle();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
